// File: rtl/conv_muladd_array.sv
// conv_muladd_array: CPF x KPF multiply-accumulate array for convolution layers.
// Each beat multiplies CPF data values by a KPF x CPF weight block, sums the
// products per kernel lane and accumulates over an eop-delimited group. On the
// group's last beat the per-kernel bias is added, then the result is rounded,
// saturated and passed through the selected activation. A result strobe
// appears exactly four cycles after the eop beat.
module conv_muladd_array #(
    parameter int CPF       = 1,
    parameter int KPF       = 1,
    parameter int DIN_DW    = 16,
    parameter int WW        = 16,
    parameter int BIAS_DW   = 16,
    parameter int DOUT_DW   = 16,
    parameter int ACC_WIDTH = 40,
    parameter int DIN_Q     = 6,
    parameter int WQ        = 13,
    parameter int BIAS_Q    = 6,
    parameter int DOUT_Q    = 6,
    parameter int ACT       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_din_en,
    input  logic                      op_din_eop,
    input  logic [CPF*DIN_DW-1:0]     op_din,
    input  logic [KPF*CPF*WW-1:0]     op_weight,
    input  logic [KPF*BIAS_DW-1:0]    op_bias,
    input  logic                      sat_clr,
    output logic [KPF*DOUT_DW-1:0]    op_dout,
    output logic                      op_dout_en,
    output logic                      op_sat_flag
);

    localparam int PW    = DIN_DW + WW;              // full product width
    localparam int SUM_W = PW + $clog2(CPF);         // per-kernel sum width
    localparam int BSH   = DIN_Q + WQ - BIAS_Q;      // bias alignment shift
    localparam int SHIFT = DIN_Q + WQ - DOUT_Q;      // output rescale shift
    localparam int RW    = ACC_WIDTH + 1;            // rounding headroom

    localparam logic signed [DOUT_DW-1:0] DOUT_MAX = {1'b0, {(DOUT_DW-1){1'b1}}};
    localparam logic signed [DOUT_DW-1:0] DOUT_MIN = {1'b1, {(DOUT_DW-1){1'b0}}};
    localparam logic signed [RW-1:0]      MAXV     = RW'(DOUT_MAX);
    localparam logic signed [RW-1:0]      MINV     = RW'(DOUT_MIN);
    localparam logic signed [RW-1:0]      HALF     = RW'(1) << (SHIFT - 1);

    // Full-precision signed product; both operands widened first so no bits are lost.
    function automatic logic signed [PW-1:0] mul(input logic signed [DIN_DW-1:0] a,
                                                 input logic signed [WW-1:0]     b);
        return PW'(a) * PW'(b);
    endfunction

    // Pipeline control shared by all lanes
    logic s1_en_d,   s1_en_q;
    logic s1_eop_d,  s1_eop_q;
    logic s2_en_d,   s2_en_q;
    logic s2_eop_d,  s2_eop_q;
    logic s3_vld_d,  s3_vld_q;
    logic dout_en_d, dout_en_q;
    logic sat_d,     sat_q;
    logic [KPF-1:0]  lane_clip;

    // Valid/eop travel with the data; eop only counts on an accepted beat.
    // A new clip wins over a coincident clear of the sticky flag.
    always_comb begin
        s1_en_d   = op_din_en;
        s1_eop_d  = op_din_en & op_din_eop;
        s2_en_d   = s1_en_q;
        s2_eop_d  = s1_eop_q;
        s3_vld_d  = s2_en_q & s2_eop_q;
        dout_en_d = s3_vld_q;
        sat_d     = (s3_vld_q & (|lane_clip)) | (sat_q & ~sat_clr);
    end

    // Control registers; reset drops every beat in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_en_q   <= 1'b0;
            s1_eop_q  <= 1'b0;
            s2_en_q   <= 1'b0;
            s2_eop_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            dout_en_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            s1_en_q   <= s1_en_d;
            s1_eop_q  <= s1_eop_d;
            s2_en_q   <= s2_en_d;
            s2_eop_q  <= s2_eop_d;
            s3_vld_q  <= s3_vld_d;
            dout_en_q <= dout_en_d;
            sat_q     <= sat_d;
        end
    end

    assign op_dout_en  = dout_en_q;
    assign op_sat_flag = sat_q;

    for (genvar gi = 0; gi < KPF; gi++) begin : g_lane
        logic [CPF*PW-1:0]           prod_d,  prod_q;
        logic signed [BIAS_DW-1:0]   bias1_d, bias1_q;
        logic signed [BIAS_DW-1:0]   bias2_d, bias2_q;
        logic signed [SUM_W-1:0]     sum_d,   sum_q;
        logic signed [ACC_WIDTH-1:0] acc_d,   acc_q;
        logic signed [ACC_WIDTH-1:0] fin_d,   fin_q;
        logic signed [ACC_WIDTH-1:0] sum_ext, bias_al;
        logic signed [RW-1:0]        rnd,     r;
        logic signed [DOUT_DW-1:0]   sat_v,   act_v;
        logic signed [DOUT_DW-1:0]   dout_d,  dout_q;
        logic                        clip;

        // S1: per-channel products for this kernel, bias captured alongside
        always_comb begin
            prod_d = '0;
            for (int c = 0; c < CPF; c++) begin
                prod_d[c*PW +: PW] = mul(op_din[c*DIN_DW +: DIN_DW],
                                         op_weight[(gi*CPF + c)*WW +: WW]);
            end
            bias1_d = op_bias[gi*BIAS_DW +: BIAS_DW];
        end

        // S2: reduce the products over input channels
        always_comb begin
            sum_d = '0;
            for (int c = 0; c < CPF; c++) begin
                sum_d = sum_d + SUM_W'($signed(prod_q[c*PW +: PW]));
            end
            bias2_d = bias1_q;
        end

        // S3: accumulate; on eop emit acc + sum + aligned bias and restart from zero
        always_comb begin
            sum_ext = ACC_WIDTH'(sum_q);
            bias_al = ACC_WIDTH'(bias2_q) <<< BSH;
            acc_d   = acc_q;
            fin_d   = fin_q;
            if (s2_en_q) begin
                if (s2_eop_q) begin
                    fin_d = acc_q + sum_ext + bias_al;
                    acc_d = '0;
                end else begin
                    acc_d = acc_q + sum_ext;
                end
            end
        end

        // S4: round half up, saturate, then activation; output holds between strobes
        always_comb begin
            rnd   = RW'(fin_q) + HALF;
            r     = rnd >>> SHIFT;
            clip  = 1'b0;
            sat_v = r[DOUT_DW-1:0];
            if (r > MAXV) begin
                sat_v = DOUT_MAX;
                clip  = 1'b1;
            end else if (r < MINV) begin
                sat_v = DOUT_MIN;
                clip  = 1'b1;
            end
            act_v = sat_v;
            if (ACT == 1 && sat_v[DOUT_DW-1]) begin
                act_v = '0;
            end else if (ACT == 2 && sat_v[DOUT_DW-1]) begin
                act_v = sat_v >>> 3;
            end
            dout_d = s3_vld_q ? act_v : dout_q;
        end

        // Lane datapath registers
        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q  <= '0;
                bias1_q <= '0;
                bias2_q <= '0;
                sum_q   <= '0;
                acc_q   <= '0;
                fin_q   <= '0;
                dout_q  <= '0;
            end else begin
                prod_q  <= prod_d;
                bias1_q <= bias1_d;
                bias2_q <= bias2_d;
                sum_q   <= sum_d;
                acc_q   <= acc_d;
                fin_q   <= fin_d;
                dout_q  <= dout_d;
            end
        end

        assign op_dout[gi*DOUT_DW +: DOUT_DW] = dout_q;
        assign lane_clip[gi]                   = clip;
    end

endmodule

// File: doc/conv_muladd_array.md
# conv_muladd_array

Parametrised CPF×KPF multiply-accumulate array for convolution layers. It consumes CPF input-channel values and a KPF×CPF weight block per beat, and accumulates each output lane over one eop-delimited group. At the group end it adds bias, then applies rounding, saturation and a selectable activation. It sits between the layer controller/RAMs and the blob output. Over a single-lane muladd it adds multi-kernel lanes, an explicit output strobe, saturating round, leaky-ReLU mode and a sticky saturation flag.

## Interface
- CPF, 1, input channels per beat (≥1)
- KPF, 1, output kernels in parallel (≥1)
- DIN_DW, 16, signed data width
- WW, 16, signed weight width
- BIAS_DW, 16, signed bias width
- DOUT_DW, 16, signed output width
- ACC_WIDTH, 40, signed accumulator width
- DIN_Q, 6, data fraction bits
- WQ, 13, weight fraction bits
- BIAS_Q, 6, bias fraction bits; DIN_Q+WQ−BIAS_Q ≥ 0
- DOUT_Q, 6, output fraction bits; SHIFT = DIN_Q+WQ−DOUT_Q ≥ 1
- ACT, 1, activation mode: 0 none, 1 ReLU, 2 leaky (negative values arithmetic-shifted right by 3)
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- op_din_en  in  1  beat valid
- op_din_eop  in  1  last beat of the group; qualified by op_din_en
- op_din  in  CPF*DIN_DW  data; lane c at [c*DIN_DW +: DIN_DW]
- op_weight  in  KPF*CPF*WW  weights; (k,c) at [(k*CPF+c)*WW +: WW]
- op_bias  in  KPF*BIAS_DW  per-kernel bias, sampled on the eop beat
- sat_clr  in  1  clears op_sat_flag
- op_dout  out  KPF*DOUT_DW  results, lane k at [k*DOUT_DW +: DOUT_DW]
- op_dout_en  out  1  one-cycle result strobe
- op_sat_flag  out  1  sticky: some lane saturated

## Operation
- Accepted beat: a cycle with op_din_en=1. op_din_eop with en=0 is ignored.
- S1: register products p[k][c] = din[c]*w[k][c], signed, DIN_DW+WW bits. Pipeline the en, eop and bias alongside.
- S2: sum products per kernel over c, width DIN_DW+WW+clog2(CPF); register the result.
- S3: per lane, acc += sum, sign-extended to ACC_WIDTH. Accumulator overflow wraps and is not flagged.
  - Eop beat: final = acc + sum + (bias <<< (DIN_Q+WQ−BIAS_Q)) is registered, and acc clears to 0 in the same cycle.
  - The next group's first beat may arrive the cycle after eop, with no bubble.
- Single-beat group (en and eop together): final = product sum + aligned bias.
- S4, per lane:
  - r = (final + 2^(SHIFT−1)) >>> SHIFT, i.e. round half toward +inf.
  - Saturate r to [−2^(DOUT_DW−1), 2^(DOUT_DW−1)−1].
  - Activation: ACT=1 maps negatives to 0. ACT=2 maps negative x to x>>>3. Activation is applied after saturation.
- op_dout registers the S4 result and holds it until the next strobe.
- op_sat_flag is set when any lane clips in S4 on a strobe cycle. It is cleared by sat_clr or rst. If set and clear coincide, set wins.

## Timing
- Eop beat accepted at cycle t → op_dout_en=1 at t+4 for exactly one cycle, with op_dout valid in the same cycle. Fixed OP_DELAY=4.
- Throughput: one beat per cycle. No backpressure; the upstream controller paces input.
- Consecutive eop beats (single-beat groups) produce strobes on consecutive cycles.
- Reset values: op_dout=0, op_dout_en=0, op_sat_flag=0, acc=0, all pipeline valids=0.
- Reset mid-group: the partial accumulation is discarded, and no strobe is emitted for any beat in flight. Beats during rst are ignored. The first group after rst deasserts starts from acc=0.

## Test plan
- Defaults, din=64, w=8192, bias=64, 3-beat group with eop on beat 3 (cycle t) → op_dout=256 at t+4, op_dout_en high for 1 cycle, op_sat_flag=0.
- Rounding, single beats with bias=0: din=1, w=4096 → 1; din=−1, w=4096 → 0; din=−64, w=8192 → 0 (ACT=1), 0xFFC0 (ACT=0), 0xFFF8 (ACT=2).
- Saturation: din=32767, w=32767, 4 beats, bias=0 → 32767 and op_sat_flag=1. Negating the weights → −32768 (ACT=0). Pulsing sat_clr clears the flag; sat_clr coinciding with a new clip leaves the flag 1.
- CPF=2, KPF=2: din={64,128}, w[0]={8192,8192}, w[1]={8192,−8192}, bias={0,64}, 2-beat group → lane0=384, lane1=0 (ACT=1), −64 (ACT=0).
- Back-to-back: groups of lengths 1, 1, 3 with no gaps, each beat din=64, w=8192, bias=0 → strobes at t1+4, t2+4, t3+4 with values 64, 64, 192. No cross-group leakage.
- Reset: rst asserted for 1 cycle after beat 2 of a 3-beat group → no strobe. A following fresh 1-beat group (din=64, w=8192) → 64.
